// File: rtl/decoder_pkg.sv
// decoder_pkg: shared select width, line count and checker FSM encoding
package decoder_pkg;
  localparam int N_SEL = 4;
  localparam int LINES = 2 ** N_SEL;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/decoder_sweep_onehot_enc.sv
// onehot_enc: combinational re-encoder of decoder select lines
// Ports: lines (lines[k] selects line k) -> idx (set-bit position),
//        is_onehot (exactly one bit set), is_zero (no bit set).
// idx is only meaningful when is_onehot is high.
module onehot_enc
  import decoder_pkg::*;
#(
  parameter int N_SEL = decoder_pkg::N_SEL,
  localparam int LINES = 2 ** N_SEL
) (
  input  logic [0:LINES-1] lines,
  output logic [N_SEL-1:0] idx,
  output logic             is_onehot,
  output logic             is_zero
);
  always_comb begin
    idx = '0;
    for (int k = 0; k < LINES; k++)
      if (lines[k]) idx = idx | N_SEL'(k);
  end
  assign is_zero   = lines == '0;
  // a word with its lowest set bit cleared is zero only when a single bit was set
  assign is_onehot = !is_zero && ((lines & (lines - LINES'(1))) == '0);
endmodule

// File: rtl/decoder_sweep_checker.sv
// decoder_sweep_checker: registered one-hot/sequence/coverage checker for a 4-to-16 decoder
// Ports: clk, rst (async active-low), en (sample enable), clr (sync clear, wins over en),
//        lines -> idx/idx_valid (last valid index + pulse), onehot_err, seq_err (pulses),
//        cov (lines seen), err_cnt (saturating error count), sweep_done (FSM in DONE).
module decoder_sweep_checker
  import decoder_pkg::*;
#(
  parameter int N_SEL     = decoder_pkg::N_SEL,
  parameter int ERR_CNT_W = 8,
  localparam int LINES    = 2 ** N_SEL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [0:LINES-1]     lines,
  output logic [N_SEL-1:0]     idx,
  output logic                 idx_valid,
  output logic                 onehot_err,
  output logic                 seq_err,
  output logic [0:LINES-1]     cov,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 sweep_done
);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
  state_t state_q, state_d;
  logic [N_SEL-1:0] idx_q, idx_d, enc_idx;
  logic [0:LINES-1] cov_q, cov_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic valid_q, valid_d, oh_err_q, oh_err_d, seq_err_q, seq_err_d, done_q, done_d;
  logic is_onehot, is_zero, sample;
  onehot_enc #(.N_SEL(N_SEL)) u_enc (
    .lines    (lines),
    .idx      (enc_idx),
    .is_onehot(is_onehot),
    .is_zero  (is_zero)
  );
  assign sample = en && !clr;
  always_comb begin
    valid_d   = sample && is_onehot;
    oh_err_d  = sample && (is_zero || !is_onehot);
    // idx_q always holds the last valid index, so the expectation is simply idx_q + 1 (wrapping)
    seq_err_d = valid_d && state_q != ST_IDLE && enc_idx != idx_q + N_SEL'(1);
    idx_d     = valid_d ? enc_idx : idx_q;
    cov_d     = clr ? '0 : valid_d ? (cov_q | lines) : cov_q;
    err_d     = clr ? '0 : ((oh_err_d || seq_err_d) && err_q != ERR_MAX) ? err_q + ERR_CNT_W'(1) : err_q;
    state_d   = state_q;
    if (clr) state_d = ST_IDLE;
    else if (valid_d && state_q != ST_DONE) state_d = (&cov_d) ? ST_DONE : ST_SWEEP;
    done_d    = state_d == ST_DONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cov_q     <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      oh_err_q  <= 1'b0;
      seq_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cov_q     <= cov_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      oh_err_q  <= oh_err_d;
      seq_err_q <= seq_err_d;
      done_q    <= done_d;
    end
  end
  assign idx        = idx_q;
  assign idx_valid  = valid_q;
  assign onehot_err = oh_err_q;
  assign seq_err    = seq_err_q;
  assign cov        = cov_q;
  assign err_cnt    = err_q;
  assign sweep_done = done_q;
endmodule
